// File: rtl/uart_rx_if.sv
// Parallel-side handshake bundle for the UART receiver.
// The receiver drives the word and its flags; the consumer answers with rx_ready.
interface uart_rx_if;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       rx_ready;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;

    modport master (
        output data_out,
        output rx_valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    modport slave (
        input  data_out,
        input  rx_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8 data bits LSB first, optional even parity, one stop bit.
// Each received byte is handed over through a valid/ready handshake together with its error flags.
module uart_rx #(
    parameter int OVERSAMPLE  = 16,
    parameter int PARITY_EN   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic     clock,
    input  logic     reset_n,
    input  logic     rx,
    input  logic     rx_tick,
    uart_rx_if.master rxIf,
    output logic     busy
);

    localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    state_e          state_q;
    logic [TW-1:0]   tickCnt_q;
    logic [2:0]      bitIdx_q;
    logic [7:0]      shift_q;
    logic            parityBit_q;
    logic            armed_q;

    logic [7:0]      dataOut_q;
    logic            valid_q;
    logic            parityErr_q;
    logic            frameErr_q;
    logic            overrun_q;

    logic            complete;
    logic            accept;

    // The line idles high, so the synchroniser resets to 1 to avoid a phantom start bit.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rxs      = sync_q[SYNC_STAGES-1];
    assign complete = rx_tick && (state_q == STOP) && (tickCnt_q == LAST_TICK);
    assign accept   = valid_q && rxIf.rx_ready;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tickCnt_q   <= '0;
            bitIdx_q    <= '0;
            shift_q     <= '0;
            parityBit_q <= 1'b0;
            armed_q     <= 1'b1;
            dataOut_q   <= '0;
            valid_q     <= 1'b0;
            parityErr_q <= 1'b0;
            frameErr_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            if ((state_q == IDLE) && rxs) begin
                armed_q <= 1'b1;
            end

            // A finished frame only replaces the held word if the consumer has taken it or takes it now.
            if (complete) begin
                if (!valid_q || rxIf.rx_ready) begin
                    dataOut_q   <= shift_q;
                    parityErr_q <= (PARITY_EN != 0) && (parityBit_q ^ (^shift_q));
                    frameErr_q  <= ~rxs;
                    valid_q     <= 1'b1;
                    overrun_q   <= 1'b0;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (accept) begin
                valid_q   <= 1'b0;
                overrun_q <= 1'b0;
            end

            if (rx_tick) begin
                case (state_q)
                    IDLE: begin
                        if (armed_q && !rxs) begin
                            state_q   <= START;
                            tickCnt_q <= '0;
                        end
                    end
                    START: begin
                        if (tickCnt_q == HALF_TICK) begin
                            tickCnt_q <= '0;
                            bitIdx_q  <= '0;
                            state_q   <= rxs ? IDLE : DATA;
                        end else begin
                            tickCnt_q <= tickCnt_q + TW'(1);
                        end
                    end
                    DATA: begin
                        if (tickCnt_q == LAST_TICK) begin
                            tickCnt_q <= '0;
                            shift_q   <= {rxs, shift_q[7:1]};
                            if (bitIdx_q == 3'd7) begin
                                state_q <= (PARITY_EN != 0) ? PARITY : STOP;
                            end else begin
                                bitIdx_q <= bitIdx_q + 3'd1;
                            end
                        end else begin
                            tickCnt_q <= tickCnt_q + TW'(1);
                        end
                    end
                    PARITY: begin
                        if (tickCnt_q == LAST_TICK) begin
                            tickCnt_q   <= '0;
                            parityBit_q <= rxs;
                            state_q     <= STOP;
                        end else begin
                            tickCnt_q <= tickCnt_q + TW'(1);
                        end
                    end
                    STOP: begin
                        // A low stop bit disarms start detection so a held break yields a single word.
                        if (tickCnt_q == LAST_TICK) begin
                            tickCnt_q <= '0;
                            state_q   <= IDLE;
                            if (!rxs) begin
                                armed_q <= 1'b0;
                            end
                        end else begin
                            tickCnt_q <= tickCnt_q + TW'(1);
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        tickCnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign rxIf.data_out   = dataOut_q;
    assign rxIf.rx_valid   = valid_q;
    assign rxIf.parity_err = parityErr_q;
    assign rxIf.frame_err  = frameErr_q;
    assign rxIf.overrun    = overrun_q;
    assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are serialised on rx while the expected words
// go into a scoreboard queue, and every handshake-accepted word is popped and compared.
module tb_uart_rx;

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } expWord_t;

    logic clock = 1'b0;
    logic reset_n;
    logic rx;
    logic rxTick;
    logic busy;

    uart_rx_if rxIf ();

    uart_rx #(
        .OVERSAMPLE (16),
        .PARITY_EN  (1),
        .SYNC_STAGES(2)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .rx     (rx),
        .rx_tick(rxTick),
        .rxIf   (rxIf),
        .busy   (busy)
    );

    expWord_t expQ[$];
    int       checkCount = 0;
    int       passCount  = 0;
    logic     sawBusy    = 1'b0;

    always #5 clock = ~clock;

    // rx_tick is high on every other clock, so bit timing also exercises the idle-tick cycles.
    initial begin
        rxTick = 1'b0;
        forever begin
            @(negedge clock);
            rxTick = ~rxTick;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end else begin
            passCount++;
        end
    endtask

    task automatic waitTicks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clock); while (rxTick !== 1'b1);
        end
        #1;
    endtask

    task automatic pushExp(input logic [7:0] data, input logic parityBit, input logic stopBit, input logic ovr);
        expWord_t e;
        e.data = data;
        e.perr = parityBit ^ (^data);
        e.ferr = ~stopBit;
        e.ovr  = ovr;
        expQ.push_back(e);
    endtask

    // Serialises one frame aligned to tick edges; with acceptAtStop the consumer pulses
    // rx_ready exactly on the clock where the receiver samples the middle of the stop bit.
    task automatic applyStimulus(input logic [7:0] data, input logic parityBit, input logic stopBit,
                                 input logic acceptAtStop);
        waitTicks(1);
        rx = 1'b0;
        waitTicks(16);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            waitTicks(16);
        end
        rx = parityBit;
        waitTicks(16);
        rx = stopBit;
        if (acceptAtStop) begin
            waitTicks(9);
            @(posedge clock);
            #1 rxIf.rx_ready = 1'b1;
            @(posedge clock);
            #1 rxIf.rx_ready = 1'b0;
            waitTicks(6);
        end else begin
            waitTicks(16);
        end
    endtask

    always @(negedge clock) begin
        if (busy === 1'b1) sawBusy = 1'b1;
    end

    always @(negedge clock) begin
        if (reset_n === 1'b1 && rxIf.rx_valid === 1'b1 && rxIf.rx_ready === 1'b1) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious_valid", {31'b0, rxIf.rx_valid}, 32'd0);
            end else begin
                expWord_t e;
                e = expQ.pop_front();
                checkOutput("data_out", {24'b0, rxIf.data_out}, {24'b0, e.data});
                checkOutput("parity_err", {31'b0, rxIf.parity_err}, {31'b0, e.perr});
                checkOutput("frame_err", {31'b0, rxIf.frame_err}, {31'b0, e.ferr});
                checkOutput("overrun", {31'b0, rxIf.overrun}, {31'b0, e.ovr});
            end
        end
    end

    initial begin
        logic [7:0] b;
        reset_n        = 1'b0;
        rx             = 1'b1;
        rxIf.rx_ready  = 1'b1;
        repeat (4) @(posedge clock);
        #1;
        checkOutput("rst_data", {24'b0, rxIf.data_out}, 32'd0);
        checkOutput("rst_valid", {31'b0, rxIf.rx_valid}, 32'd0);
        checkOutput("rst_perr", {31'b0, rxIf.parity_err}, 32'd0);
        checkOutput("rst_ferr", {31'b0, rxIf.frame_err}, 32'd0);
        checkOutput("rst_ovr", {31'b0, rxIf.overrun}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        waitTicks(4);

        $display("[TB] clean frames");
        pushExp(8'hA5, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        pushExp(8'h01, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h01, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        waitTicks(4);

        $display("[TB] break condition");
        pushExp(8'h3C, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0);
        waitTicks(32);
        checkOutput("break_no_restart", {31'b0, busy}, 32'd0);
        checkOutput("break_one_word", expQ.size(), 32'd0);
        rx = 1'b1;
        waitTicks(8);
        b = 8'hC3;
        pushExp(b, ^b, 1'b1, 1'b0);
        applyStimulus(b, ^b, 1'b1, 1'b0);
        rx = 1'b1;
        waitTicks(4);
        checkOutput("after_break_word", expQ.size(), 32'd0);

        $display("[TB] start glitch");
        sawBusy = 1'b0;
        rx = 1'b0;
        waitTicks(5);
        rx = 1'b1;
        waitTicks(8);
        checkOutput("glitch_busy_seen", {31'b0, sawBusy}, 32'd1);
        checkOutput("glitch_busy_end", {31'b0, busy}, 32'd0);
        waitTicks(16);

        $display("[TB] overrun and same-cycle accept");
        rxIf.rx_ready = 1'b0;
        pushExp(8'h11, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'h11, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        waitTicks(4);
        applyStimulus(8'h22, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        waitTicks(4);
        @(negedge clock);
        checkOutput("ovr_valid_held", {31'b0, rxIf.rx_valid}, 32'd1);
        checkOutput("ovr_data_held", {24'b0, rxIf.data_out}, 32'h11);
        checkOutput("ovr_flag", {31'b0, rxIf.overrun}, 32'd1);
        @(posedge clock);
        #1 rxIf.rx_ready = 1'b1;
        @(posedge clock);
        #1 rxIf.rx_ready = 1'b0;
        @(negedge clock);
        checkOutput("accept_valid_clr", {31'b0, rxIf.rx_valid}, 32'd0);
        checkOutput("accept_ovr_clr", {31'b0, rxIf.overrun}, 32'd0);
        pushExp(8'h33, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h33, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;
        waitTicks(4);
        b = 8'h44;
        pushExp(b, ^b, 1'b1, 1'b0);
        applyStimulus(b, ^b, 1'b1, 1'b1);
        rx = 1'b1;
        @(negedge clock);
        checkOutput("same_cycle_valid", {31'b0, rxIf.rx_valid}, 32'd1);
        checkOutput("same_cycle_data", {24'b0, rxIf.data_out}, 32'h44);
        checkOutput("same_cycle_ovr", {31'b0, rxIf.overrun}, 32'd0);
        @(posedge clock);
        #1 rxIf.rx_ready = 1'b1;
        waitTicks(4);

        $display("[TB] reset mid-frame");
        b = 8'h7E;
        waitTicks(1);
        rx = 1'b0;
        waitTicks(16);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            waitTicks(16);
        end
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'b0, rxIf.rx_valid}, 32'd0);
        checkOutput("midrst_data", {24'b0, rxIf.data_out}, 32'd0);
        checkOutput("midrst_busy", {31'b0, busy}, 32'd0);
        checkOutput("midrst_ferr", {31'b0, rxIf.frame_err}, 32'd0);
        checkOutput("midrst_perr", {31'b0, rxIf.parity_err}, 32'd0);
        rx = 1'b1;
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        waitTicks(4);
        pushExp(8'h5A, 1'b0, 1'b1, 1'b0);
        applyStimulus(8'h5A, 1'b0, 1'b1, 1'b0);
        rx = 1'b1;

        for (int i = 0; i < 200 && expQ.size() != 0; i++) @(posedge clock);
        #1;
        checkOutput("queue_drained", expQ.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
